llr_pe_array: RTL and testbench

- Parametrised, pipelined successor to the single combinational LLR f/g unit.
- Processes LANES LLR pairs per beat under one mode select:
  - f: min-sum.
  - g: partial-sum-controlled add/subtract.
- Results are saturated to symmetric range; per-lane saturation flags and a running saturation counter are reported.
- Sits between the LLR memory read path and write-back in the SC decoder, with valid/ready handshake on both sides.

---
 rtl/llr_pe_array.sv | 152 +++++++++++++++
 tb/tb_llr_pe_array.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/llr_pe_array.sv
`default_nettype none
// ============================================================================
//  Module      : llr_pe_array
//  Description : Pipelined array of LLR processing elements for an SC polar
//                decoder. Each beat carries LANES LLR pairs; the whole beat is
//                processed as f (min-sum) or g (partial-sum add/subtract).
//                Results are clamped to the symmetric range
//                [-(2^(W-1)-1), 2^(W-1)-1], with per-lane clamp flags and a
//                sticky running count of clamp events.
//  Revision    : 1.0 - initial two-stage pipelined release
// ============================================================================
module llr_pe_array #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          sel,
    input  logic [LANES-1:0]              us,
    input  logic [LANES*DATA_WIDTH-1:0]   a,
    input  logic [LANES*DATA_WIDTH-1:0]   b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   llr_out,
    output logic [LANES-1:0]              sat_flags,
    output logic [CNT_WIDTH-1:0]          sat_count,
    input  logic                          clr_count
);

    // One extra bit holds every unsaturated f/g result (including |-2^(W-1)|
    // and the full b +/- a range) without overflow.
    localparam int c_RAW_W = DATA_WIDTH + 1;

    // Symmetric clamp limits, expressed in the wide raw domain.
    localparam logic signed [c_RAW_W-1:0] c_MAXV = {2'b00, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [c_RAW_W-1:0] c_MINV = {2'b11, {(DATA_WIDTH-2){1'b0}}, 1'b1};

    logic                          w_advance;
    logic [LANES*c_RAW_W-1:0]      w_raw;
    logic [LANES*DATA_WIDTH-1:0]   w_sat_val;
    logic [LANES-1:0]              w_sat_flag;

    logic                          r_s1_valid;
    logic [LANES*c_RAW_W-1:0]      r_s1_raw;
    logic                          r_s2_valid;
    logic [LANES*DATA_WIDTH-1:0]   r_s2_val;
    logic [LANES-1:0]              r_s2_flags;
    logic [CNT_WIDTH-1:0]          r_sat_count;

    logic [CNT_WIDTH:0]            w_pop;
    logic [CNT_WIDTH:0]            w_sum;
    logic [CNT_WIDTH-1:0]          w_cnt_next;

    // The pipeline moves as a whole whenever the output slot is free or
    // being drained; bubbles travel with it rather than being collapsed.
    assign w_advance = !r_s2_valid || out_ready;
    assign in_ready  = w_advance && !rst;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [c_RAW_W-1:0] w_a;
        logic signed [c_RAW_W-1:0] w_b;
        logic signed [c_RAW_W-1:0] w_abs_a;
        logic signed [c_RAW_W-1:0] w_abs_b;
        logic signed [c_RAW_W-1:0] w_mag;
        logic signed [c_RAW_W-1:0] w_f;
        logic signed [c_RAW_W-1:0] w_g;
        logic                      w_neg;
        logic signed [c_RAW_W-1:0] w_r;
        logic                      w_hi;
        logic                      w_lo;

        // Sign-extend into the wide domain so |x| and b +/- a never wrap.
        assign w_a = {a[i*DATA_WIDTH + DATA_WIDTH-1], a[i*DATA_WIDTH +: DATA_WIDTH]};
        assign w_b = {b[i*DATA_WIDTH + DATA_WIDTH-1], b[i*DATA_WIDTH +: DATA_WIDTH]};

        // f: min-sum; zero counts as positive so only true negatives flip sign.
        assign w_abs_a = w_a[c_RAW_W-1] ? -w_a : w_a;
        assign w_abs_b = w_b[c_RAW_W-1] ? -w_b : w_b;
        assign w_mag   = (w_abs_a < w_abs_b) ? w_abs_a : w_abs_b;
        assign w_neg   = w_a[c_RAW_W-1] ^ w_b[c_RAW_W-1];
        assign w_f     = w_neg ? -w_mag : w_mag;

        // g: the partial sum decides whether a is added to or taken from b.
        assign w_g = us[i] ? (w_b - w_a) : (w_b + w_a);

        assign w_raw[i*c_RAW_W +: c_RAW_W] = sel ? w_f : w_g;

        // Clamp the registered raw value to the symmetric output range.
        assign w_r  = r_s1_raw[i*c_RAW_W +: c_RAW_W];
        assign w_hi = (w_r > c_MAXV);
        assign w_lo = (w_r < c_MINV);

        assign w_sat_flag[i] = w_hi || w_lo;
        assign w_sat_val[i*DATA_WIDTH +: DATA_WIDTH] =
            w_hi ? c_MAXV[DATA_WIDTH-1:0] :
            w_lo ? c_MINV[DATA_WIDTH-1:0] :
                   w_r[DATA_WIDTH-1:0];
    end

    // Pipeline registers: S1 holds raw lane results, S2 the clamped beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_raw   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_val   <= '0;
            r_s2_flags <= '0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            // Operands are only captured on an accepted beat.
            if (in_valid) begin
                r_s1_raw <= w_raw;
            end
            r_s2_valid <= r_s1_valid;
            r_s2_val   <= w_sat_val;
            r_s2_flags <= w_sat_flag;
        end
    end

    // Number of clamped lanes in the beat currently presented at the output.
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            w_pop = w_pop + {{CNT_WIDTH{1'b0}}, r_s2_flags[k]};
        end
    end

    // Carry out of the widened add means the counter would pass all-ones.
    assign w_sum      = {1'b0, r_sat_count} + w_pop;
    assign w_cnt_next = w_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];

    // Sticky clamp-event counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (clr_count) begin
            r_sat_count <= '0;
        end else if (r_s2_valid && out_ready) begin
            r_sat_count <= w_cnt_next;
        end
    end

    assign out_valid = r_s2_valid;
    assign llr_out   = r_s2_val;
    assign sat_flags = r_s2_flags;
    assign sat_count = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_llr_pe_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_llr_pe_array
//  Description : Self-checking bench for llr_pe_array. Table of hand-computed
//                f/g vectors plus directed sequences for latency, throughput,
//                back-pressure, mid-flight reset and counter saturation/clear.
//  Revision    : 1.0 - initial bench
// ============================================================================
module tb_llr_pe_array;

    typedef struct packed {
        logic        sel;
        logic [3:0]  us;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        logic [3:0]  ef;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        sel;
    logic        out_ready;
    logic        clr_count;
    logic [3:0]  us;
    logic [31:0] a;
    logic [31:0] b;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] llr_out;
    logic [3:0]  sat_flags;
    logic [15:0] sat_count;

    logic        in_ready_c;
    logic        out_valid_c;
    logic [31:0] llr_out_c;
    logic [3:0]  sat_flags_c;
    logic [2:0]  sat_count_c;

    int   n_tests;
    int   n_fail;
    vec_t tbl [6];

    llr_pe_array #(.DATA_WIDTH(8), .LANES(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .us(us), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .llr_out(llr_out),
        .sat_flags(sat_flags), .sat_count(sat_count), .clr_count(clr_count)
    );

    llr_pe_array #(.DATA_WIDTH(8), .LANES(4), .CNT_WIDTH(3)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .sel(sel), .us(us), .a(a), .b(b),
        .out_valid(out_valid_c), .out_ready(out_ready), .llr_out(llr_out_c),
        .sat_flags(sat_flags_c), .sat_count(sat_count_c), .clr_count(clr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] p4(int x0, int x1, int x2, int x3);
        logic [31:0] r;
        r[7:0]   = x0[7:0];
        r[15:8]  = x1[7:0];
        r[23:16] = x2[7:0];
        r[31:24] = x3[7:0];
        return r;
    endfunction

    function automatic vec_t mk(logic s, logic [3:0] u, logic [31:0] va,
                                logic [31:0] vb, logic [31:0] ve, logic [3:0] vf);
        vec_t v;
        v.sel = s; v.us = u; v.a = va; v.b = vb; v.e = ve; v.ef = vf;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int idx, logic v);
        in_valid = v;
        sel      = tbl[idx].sel;
        us       = tbl[idx].us;
        a        = tbl[idx].a;
        b        = tbl[idx].b;
    endtask

    initial begin
        int          exp_cnt;
        int          p;
        int          q;
        logic        prev_stall;
        logic [31:0] prev_llr;
        logic        saw_not_ready;
        logic        fire_in;
        logic        fire_out;
        logic        exp_v;

        n_tests = 0;
        n_fail  = 0;
        // Lane 0 is the first element of each list (lowest bits).
        tbl[0] = mk(1'b1, 4'b0000, p4(-5, 7, -128, 0),      p4(3, -2, -100, -9),
                    p4(-3, -2, 100, 0),        4'b0000);
        tbl[1] = mk(1'b0, 4'b0110, p4(100, 100, -100, -128), p4(100, -100, 100, -128),
                    p4(127, -127, 127, -127),  4'b1111);
        tbl[2] = mk(1'b1, 4'b0000, p4(-128, -128, 127, -1),  p4(-128, 127, -128, 1),
                    p4(127, -127, -127, -1),   4'b0001);
        tbl[3] = mk(1'b0, 4'b1100, p4(10, -20, 30, -128),    p4(5, 7, -2, 0),
                    p4(15, -13, -32, 127),     4'b1000);
        tbl[4] = mk(1'b0, 4'b1001, p4(0, 63, -64, 127),      p4(0, 64, -64, -1),
                    p4(0, 127, -127, -127),    4'b1100);
        tbl[5] = mk(1'b1, 4'b0000, p4(0, 0, 50, -50),        p4(0, -1, -60, 40),
                    p4(0, 0, -50, -40),        4'b0000);

        rst = 1'b1; in_valid = 1'b0; sel = 1'b0; us = '0; a = '0; b = '0;
        out_ready = 1'b1; clr_count = 1'b0;

        // ---------------- reset state
        repeat (3) step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_llr_out",   llr_out, 32'd0);
        chk("rst_sat_flags", {28'd0, sat_flags}, 32'd0);
        chk("rst_sat_count", {16'd0, sat_count}, 32'd0);
        rst = 1'b0;
        step();

        // ---------------- single beats: latency, data, flags, counter
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive(i, 1'b1);
            step();
            in_valid = 1'b0;
            chk("lat1_valid", {31'd0, out_valid}, 32'd0);
            step();
            chk("lat2_valid", {31'd0, out_valid}, 32'd1);
            chk("vec_llr",    llr_out, tbl[i].e);
            chk("vec_flags",  {28'd0, sat_flags}, {28'd0, tbl[i].ef});
            exp_cnt += $countones(tbl[i].ef);
            step();
            chk("vec_count",  {16'd0, sat_count}, exp_cnt);
        end

        // ---------------- full throughput, 20 beats
        for (int c = 0; c < 23; c++) begin
            if (c < 20) drive(c % 6, 1'b1);
            else in_valid = 1'b0;
            #1;
            chk("tp_in_ready", {31'd0, in_ready}, 32'd1);
            step();
            exp_v = (c >= 1) && (c <= 20);
            chk("tp_valid", {31'd0, out_valid}, {31'd0, exp_v});
            if (exp_v) begin
                chk("tp_data", llr_out, tbl[(c-1) % 6].e);
                exp_cnt += $countones(tbl[(c-1) % 6].ef);
            end
        end
        chk("tp_count", {16'd0, sat_count}, exp_cnt);

        // ---------------- back-pressure: out_ready low for cycles 3..7
        p = 0; q = 0; prev_stall = 1'b0; prev_llr = '0; saw_not_ready = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 7);
            if (p < 6) drive(p, 1'b1);
            else in_valid = 1'b0;
            #1;
            if (!in_ready) saw_not_ready = 1'b1;
            if (prev_stall) begin
                chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_hold_llr",   llr_out, prev_llr);
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                if (q < 6) begin
                    chk("bp_order", llr_out, tbl[q].e);
                    exp_cnt += $countones(tbl[q].ef);
                end else begin
                    chk("bp_extra_beat", {31'd0, out_valid}, 32'd0);
                end
                q++;
            end
            prev_stall = out_valid && !out_ready;
            prev_llr   = llr_out;
            if (fire_in) p++;
            step();
        end
        chk("bp_delivered", q, 6);
        chk("bp_in_ready_dropped", {31'd0, saw_not_ready}, 32'd1);
        chk("bp_count", {16'd0, sat_count}, exp_cnt);

        // ---------------- reset with two beats in flight
        out_ready = 1'b1;
        drive(1, 1'b1);
        step();
        drive(3, 1'b1);
        step();
        in_valid = 1'b0;
        chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_llr_out",   llr_out, 32'd0);
        chk("mid_sat_count", {16'd0, sat_count}, 32'd0);
        chk("mid_sat_flags", {28'd0, sat_flags}, 32'd0);
        chk("mid_in_ready",  {31'd0, in_ready}, 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mid_no_stale", {31'd0, out_valid}, 32'd0);
        end
        drive(0, 1'b1);
        step();
        in_valid = 1'b0;
        chk("mid_new_lat1", {31'd0, out_valid}, 32'd0);
        step();
        chk("mid_new_lat2", {31'd0, out_valid}, 32'd1);
        chk("mid_new_llr",  llr_out, tbl[0].e);
        step();

        // ---------------- counter stickiness (3-bit instance) and clear
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b1);
            step();
            if (k == 2) chk("cnt_c_first", {29'd0, sat_count_c}, 32'd4);
        end
        in_valid = 1'b0;
        repeat (3) step();
        chk("cnt_c_sticky", {29'd0, sat_count_c}, 32'd7);
        chk("cnt_main_12",  {16'd0, sat_count}, 32'd12);

        drive(1, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        chk("clr_pre_flags", {28'd0, sat_flags}, 32'hF);
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        chk("clr_main",   {16'd0, sat_count}, 32'd0);
        chk("clr_c",      {29'd0, sat_count_c}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
